// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-time divider helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    function automatic int calc_divider(input int freq_in, input int baud);
        return freq_in / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling asynchronous serial receiver with framing-error detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ_IN   = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_N,
    input  logic                 RX_IN,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 FRAME_ERROR,
    output logic                 BUSY
);

    localparam int DIVIDER = calc_divider(FREQ_IN, BAUD);
    localparam int HALF    = DIVIDER / 2;
    localparam int CNT_W   = $clog2(DIVIDER);
    localparam int IDX_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (DIVIDER < 4) begin : g_bad_divider
            $error("uart_rx: FREQ_IN/BAUD must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx: DATA_BITS must be within 5..9");
        end
    endgenerate

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (CLK_IN),
        .rst_n (RESET_N),
        .d     (RX_IN),
        .q     (rx_s)
    );

    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            DATA_VALID  <= 1'b0;
            FRAME_ERROR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                // A start bit that is already high again at mid-bit is a glitch.
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            DATA_OUT   <= shreg;
                            DATA_VALID <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            FRAME_ERROR <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Hold off until the line idles so a long break cannot look like new frames.
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx at 12 MHz / 115200 baud
module tb_uart_rx;

    localparam int DIV = 104;

    logic       CLK_IN  = 1'b0;
    logic       RESET_N = 1'b0;
    logic       RX_IN   = 1'b1;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       FRAME_ERROR;
    logic       BUSY;

    uart_rx #(.FREQ_IN(12000000), .BAUD(115200), .DATA_BITS(8)) dut (
        .CLK_IN      (CLK_IN),
        .RESET_N     (RESET_N),
        .RX_IN       (RX_IN),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .FRAME_ERROR (FRAME_ERROR),
        .BUSY        (BUSY)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   n_strobe = 0;
    int   strobe_cyc = 0;
    bit   prev_strobe = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic is_err);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic send_byte(input logic [7:0] d, input int per, input logic stop);
        RX_IN = 1'b0;
        idle(per);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            idle(per);
        end
        RX_IN = stop;
        idle(per);
    endtask

    // Scoreboard consumer: every strobe pops one expected event.
    always @(negedge CLK_IN) begin
        exp_t e;
        if (RESET_N) begin
            if (prev_strobe) check("strobe_one_cycle", {DATA_VALID, FRAME_ERROR}, 0);
            if (DATA_VALID || FRAME_ERROR) begin
                n_strobe++;
                strobe_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {DATA_VALID, FRAME_ERROR}, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", {DATA_VALID, FRAME_ERROR}, e.is_err ? 2'b01 : 2'b10);
                    check("data_out", DATA_OUT, e.data);
                    check("busy_at_strobe", BUSY, e.is_err);
                end
            end
            prev_strobe = DATA_VALID || FRAME_ERROR;
        end
    end

    initial begin
        int fall_cyc;
        int lat;
        int n0;
        int busy_cnt;

        idle(3);
        check("reset_data_out", DATA_OUT, 0);
        check("reset_data_valid", DATA_VALID, 0);
        check("reset_frame_error", FRAME_ERROR, 0);
        check("reset_busy", BUSY, 0);
        RESET_N = 1'b1;
        idle(5);

        expect_word(8'h55, 1'b0);
        strobe_cyc = 0;
        fall_cyc = cyc;
        send_byte(8'h55, DIV, 1'b1);
        idle(20);
        check("drain_55", sb.size(), 0);
        lat = strobe_cyc - fall_cyc;
        total++;
        assert (lat >= 988 && lat <= 992) passed++;
        else $error("FAIL latency_55: observed %0d expected 988..992", lat);

        n0 = n_strobe;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            RX_IN = (i < 20) ? 1'b0 : 1'b1;
            @(negedge CLK_IN);
            if (BUSY) busy_cnt++;
        end
        check("glitch_no_strobe", n_strobe, n0);
        check("glitch_data_kept", DATA_OUT, 8'h55);
        total++;
        assert (busy_cnt >= 50 && busy_cnt <= 54) passed++;
        else $error("FAIL glitch_busy_len: observed %0d expected 50..54", busy_cnt);

        n0 = n_strobe;
        expect_word(8'h3C, 1'b0);
        send_byte(8'h3C, DIV, 1'b1);
        idle(20);
        expect_word(8'h3C, 1'b1);
        send_byte(8'hA3, DIV, 1'b0);
        idle(2000);
        check("drain_break", sb.size(), 0);
        check("break_strobe_count", n_strobe - n0, 2);
        check("break_data_kept", DATA_OUT, 8'h3C);
        check("break_busy", BUSY, 1);
        RX_IN = 1'b1;
        idle(20);
        check("break_released", BUSY, 0);
        expect_word(8'h0F, 1'b0);
        send_byte(8'h0F, DIV, 1'b1);
        idle(20);
        check("drain_0f", sb.size(), 0);

        expect_word(8'h00, 1'b0);
        expect_word(8'hFF, 1'b0);
        expect_word(8'h81, 1'b0);
        send_byte(8'h00, DIV, 1'b1);
        send_byte(8'hFF, DIV, 1'b1);
        send_byte(8'h81, DIV, 1'b1);
        idle(20);
        check("drain_b2b", sb.size(), 0);

        expect_word(8'hC6, 1'b0);
        send_byte(8'hC6, 102, 1'b1);
        idle(30);
        check("drain_fast", sb.size(), 0);
        expect_word(8'hC6, 1'b0);
        send_byte(8'hC6, 106, 1'b1);
        idle(30);
        check("drain_slow", sb.size(), 0);

        RX_IN = 1'b0;
        idle(DIV);
        for (int i = 0; i < 4; i++) begin
            RX_IN = 1'((8'h7E >> i) & 8'h01);
            idle(DIV);
        end
        RX_IN = 1'b1;
        idle(50);
        RESET_N = 1'b0;
        #1;
        check("midreset_data_out", DATA_OUT, 0);
        check("midreset_valid", DATA_VALID, 0);
        check("midreset_ferr", FRAME_ERROR, 0);
        check("midreset_busy", BUSY, 0);
        idle(5);
        RESET_N = 1'b1;
        idle(10);
        expect_word(8'h7E, 1'b0);
        send_byte(8'h7E, DIV, 1'b1);
        idle(20);
        check("drain_7e", sb.size(), 0);
        check("final_data_out", DATA_OUT, 8'h7E);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 by default. It is the receive-side counterpart of the divider-tick transmit path in the UART examples.
- Oversamples RX_IN with the system clock, using a free-standing bit-time counter derived from FREQ_IN/BAUD.
- Validates the start bit at mid-bit, samples the data bits LSB first at their centres, and checks the stop bit.
- Presents each byte with a one-cycle valid strobe, or flags a framing error instead.

Parameters:
- FREQ_IN, 12000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate in bits/s.
- DATA_BITS, 8, data bits per frame (5..9).

Ports:
- CLK_IN  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset, deasserted synchronously by the system.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK_IN.
- DATA_OUT  output  DATA_BITS  last correctly received word, LSB = first bit on the line.
- DATA_VALID  output  1  high for exactly one cycle when DATA_OUT is updated.
- FRAME_ERROR  output  1  high for exactly one cycle when a stop bit is sampled low.
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Constants:
  - DIVIDER = FREQ_IN/BAUD (integer division).
  - HALF = DIVIDER/2.
  - Counter width is $clog2(DIVIDER).
  - Elaboration fails if DIVIDER < 4.
- Reset (async, RESET_N low):
  - Outputs: DATA_OUT=0, DATA_VALID=0, FRAME_ERROR=0, BUSY=0.
  - State=IDLE; counter=0; bit index=0; shift register=0.
  - Both synchronizer flops are set to 1.
- Synchronizer: RX_IN passes through 2 flops to give rx_s. All decisions use rx_s only, so there is 2 cycles of input latency.
- IDLE:
  - rx_s==0 -> START, counter=0.
  - Otherwise stay.
- START:
  - Counter increments each cycle.
  - At counter==HALF-1:
    - rx_s==0 -> DATA, counter=0, bit index=0.
    - rx_s==1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - At counter==DIVIDER-1: shift rx_s in at the MSB end (right shift, so the first bit lands at LSB after DATA_BITS shifts), counter=0, bit index++.
  - After the DATA_BITS-th sample -> STOP.
- STOP, at counter==DIVIDER-1:
  - rx_s==1 -> load DATA_OUT from the shift register, DATA_VALID=1 for the next cycle, -> IDLE.
  - rx_s==0 -> FRAME_ERROR=1 for the next cycle; DATA_OUT keeps its previous value; -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE.
  - Prevents a held-low line (break) from retriggering frames.
- Strobes:
  - DATA_VALID and FRAME_ERROR are registered, mutually exclusive, and cleared the cycle after they assert.
  - There is no backpressure; a consumer that misses the strobe loses the byte.
- Timing: the stop-bit sample edge occurs HALF + (DATA_BITS+1)*DIVIDER cycles after the first rx_s==0 cycle.
- Back-to-back frames: the receiver returns to IDLE at mid stop bit. The next start edge, at the earliest 0.5 bit later, is caught without loss.
- Counter never exceeds DIVIDER-1; there is no wrap ambiguity.
- Reset mid-frame aborts immediately with no strobe. After release, a partial frame still low on the line is treated as a new start edge (accepted behaviour).

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, STOP, BREAK.
  - Function computing DIVIDER from FREQ_IN and BAUD.
  - Also used by the transmitter.
- One sub-module: sync_2ff (2-flop synchronizer with parameterised reset value, 1 here). Reusable for other async inputs.

Test Plan (FREQ_IN=12000000, BAUD=115200, DIVIDER=104, HALF=52):
- Send 0x55 8N1 at the exact baud rate -> DATA_OUT=0x55 and DATA_VALID high 1 cycle, 990±2 cycles after the RX_IN falling edge; FRAME_ERROR stays 0; BUSY falls with the strobe.
- RX_IN low pulse of 20 cycles while idle -> no strobes; BUSY high about 52 cycles, then 0; DATA_OUT unchanged.
- Receive 0x3C, then send 0xA3 with stop bit 0 and hold RX_IN low 2000 cycles -> FRAME_ERROR 1 cycle; DATA_OUT stays 0x3C; no further strobes while low. After RX_IN returns high, a good 0x0F -> DATA_VALID with 0x0F.
- Back-to-back 0x00, 0xFF, 0x81 with 1 stop bit each -> three DATA_VALID pulses with matching values, no FRAME_ERROR.
- Transmitter at ±2% baud (bit periods 102 and 106 cycles) sending 0xC6 -> received correctly both times.
- Assert RESET_N low during bit 4 of a frame -> all outputs 0 immediately. Release with the line idle, then send 0x7E -> correct reception.
